// File: rtl/binary_tree_adder_pipe_pkg.sv
// tree_adder_pkg: shared sizing helpers for adder trees (this block and the accumulator).
package tree_adder_pkg;
  function automatic int tree_levels(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic int level_width(int p, int k);
    return p + k;
  endfunction
endpackage

// File: rtl/binary_tree_adder_pipe_if.sv
// binary_tree_adder_pipe_if: operand/result bundle for the adder tree.
interface binary_tree_adder_pipe_if #(
  parameter int P = 8,
  parameter int INPUTS_AMOUNT = 8,
  parameter int OUT_W = 32
);
  logic valid_in;
  logic signed [P-1:0] inputs [INPUTS_AMOUNT];
  logic valid_out;
  logic signed [OUT_W-1:0] out;
  modport master(output valid_in, inputs, input valid_out, out);
  modport slave(input valid_in, inputs, output valid_out, out);
endinterface

// File: rtl/binary_tree_adder_pipe_level.sv
// tree_adder_level: one tree level, pairwise sign-extended adds, optionally registered.
module tree_adder_level #(
  parameter int IN_W = 8,
  parameter int N_IN = 2,
  parameter int REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  input  logic signed [IN_W-1:0] din [N_IN],
  output logic valid_o,
  output logic signed [IN_W:0] dout [N_IN/2]
);
  localparam int N_OUT = N_IN / 2;
  logic signed [IN_W:0] sum_d [N_OUT];
  logic valid_d;
  always_comb begin
    valid_d = valid_i;
    for (int i = 0; i < N_OUT; i++)
      sum_d[i] = {din[2*i][IN_W-1], din[2*i]} + {din[2*i+1][IN_W-1], din[2*i+1]};
  end
  if (REG != 0) begin : g_reg
    logic signed [IN_W:0] sum_q [N_OUT];
    logic valid_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sum_q <= '{default: '0};
      end else begin
        valid_q <= valid_d;
        if (valid_d) sum_q <= sum_d;
      end
    end
    assign dout = sum_q;
    assign valid_o = valid_q;
  end else begin : g_comb
    assign dout = sum_d;
    assign valid_o = valid_d;
  end
endmodule

// File: rtl/binary_tree_adder_pipe.sv
// binary_tree_adder_pipe: exact signed sum of INPUTS_AMOUNT operands via a balanced adder tree.
module binary_tree_adder_pipe
  import tree_adder_pkg::*;
#(
  parameter int P = 8,
  parameter int INPUTS_AMOUNT = 8,
  parameter int OUT_W = 32,
  parameter int PIPELINED = 1
) (
  input logic clk,
  input logic rst_n,
  binary_tree_adder_pipe_if.slave bus
);
  localparam int L = tree_levels(INPUTS_AMOUNT);
  localparam int NP = 1 << L;
  if (OUT_W < P + $clog2(INPUTS_AMOUNT)) begin : g_bad_width
    $error("OUT_W too narrow for P and INPUTS_AMOUNT");
  end
  logic signed [P-1:0] pad [NP];
  for (genvar i = 0; i < NP; i++) begin : g_pad
    if (i < INPUTS_AMOUNT) begin : g_op
      assign pad[i] = bus.inputs[i];
    end else begin : g_zero
      assign pad[i] = '0;
    end
  end
  // last level is always registered so the unpipelined tree still has one output register
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int W = level_width(P, k);
    localparam int N = NP >> k;
    logic signed [W-1:0] din [N];
    logic signed [W:0] dout [N/2];
    logic valid_i, valid_o;
    if (k == 0) begin : g_first
      assign din = pad;
      assign valid_i = bus.valid_in;
    end else begin : g_next
      assign din = g_lvl[k-1].dout;
      assign valid_i = g_lvl[k-1].valid_o;
    end
    tree_adder_level #(
      .IN_W(W),
      .N_IN(N),
      .REG(int'(PIPELINED != 0 || k == L - 1))
    ) u_level (
      .clk(clk),
      .rst_n(rst_n),
      .valid_i(valid_i),
      .din(din),
      .valid_o(valid_o),
      .dout(dout)
    );
  end
  assign bus.out = OUT_W'(g_lvl[L-1].dout[0]);
  assign bus.valid_out = g_lvl[L-1].valid_o;
endmodule

// File: tb/tb_binary_tree_adder_pipe.sv
// tb_binary_tree_adder_pipe: scoreboard bench over pipelined, combinational, 5-input and 1-input trees.
module tb_binary_tree_adder_pipe;
  typedef struct packed {
    logic signed [31:0] val;
    int due;
  } sb_t;
  logic clk, rst_n;
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  sb_t q[4][$];
  logic v8, v5, v1;
  logic signed [7:0] ops8 [8];
  logic signed [7:0] ops5 [5];
  logic signed [7:0] ops1 [1];
  logic vo [4];
  logic signed [31:0] oo [4];
  int dir [5][8] = '{'{1, 2, 3, 4, 5, 6, 7, 8}, '{1, -2, 3, -4, 5, -6, 7, -8},
                     '{127, -128, 0, 1, 0, 0, 0, 0}, '{127, 5, 2, 1, 6, 1, 35, 6},
                     '{-127, 5, 2, 1, -6, 1, -35, 6}};
  int dexp [5] = '{36, -4, 0, 183, -153};
  int all_n [8] = '{default: -128};
  int all_p [8] = '{default: 127};
  int bub_a [8] = '{10, 20, 30, 40, -5, -5, 0, 1};
  int bub_b [8] = '{-1, -2, -3, -4, -5, -6, -7, -8};
  int r [8];
  int n5a [5] = '{1, 2, 3, 4, -20};
  int n5b [5] = '{default: -128};
  int hold_val;

  binary_tree_adder_pipe_if #(.P(8), .INPUTS_AMOUNT(8), .OUT_W(32)) if_p ();
  binary_tree_adder_pipe_if #(.P(8), .INPUTS_AMOUNT(8), .OUT_W(32)) if_c ();
  binary_tree_adder_pipe_if #(.P(8), .INPUTS_AMOUNT(5), .OUT_W(32)) if_5 ();
  binary_tree_adder_pipe_if #(.P(8), .INPUTS_AMOUNT(1), .OUT_W(32)) if_1 ();

  binary_tree_adder_pipe #(.P(8), .INPUTS_AMOUNT(8), .OUT_W(32), .PIPELINED(1)) u_p (
    .clk(clk), .rst_n(rst_n), .bus(if_p));
  binary_tree_adder_pipe #(.P(8), .INPUTS_AMOUNT(8), .OUT_W(32), .PIPELINED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));
  binary_tree_adder_pipe #(.P(8), .INPUTS_AMOUNT(5), .OUT_W(32), .PIPELINED(1)) u_5 (
    .clk(clk), .rst_n(rst_n), .bus(if_5));
  binary_tree_adder_pipe #(.P(8), .INPUTS_AMOUNT(1), .OUT_W(32), .PIPELINED(1)) u_1 (
    .clk(clk), .rst_n(rst_n), .bus(if_1));

  assign if_p.valid_in = v8;
  assign if_p.inputs = ops8;
  assign if_c.valid_in = v8;
  assign if_c.inputs = ops8;
  assign if_5.valid_in = v5;
  assign if_5.inputs = ops5;
  assign if_1.valid_in = v1;
  assign if_1.inputs = ops1;
  assign vo = '{if_p.valid_out, if_c.valid_out, if_5.valid_out, if_1.valid_out};
  assign oo = '{if_p.out, if_c.out, if_5.out, if_1.out};

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // output monitor: every valid_out must match the oldest pending entry on its due cycle
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (q[d].size() != 0 && q[d][0].due < cyc) begin
        check($sformatf("missed%0d", d), 0, q[d][0].val);
        void'(q[d].pop_front());
      end
      if (vo[d]) begin
        if (q[d].size() == 0) check($sformatf("spurious%0d", d), 1, 0);
        else begin
          check($sformatf("sum%0d", d), oo[d], q[d][0].val);
          check($sformatf("lat%0d", d), cyc, q[d][0].due);
          void'(q[d].pop_front());
        end
      end
    end
  end

  function automatic int sum8(input int v [8]);
    int s = 0;
    for (int j = 0; j < 8; j++) s += v[j];
    return s;
  endfunction

  task automatic send8(input int v [8], input int e);
    @(negedge clk);
    v8 = 1;
    for (int j = 0; j < 8; j++) ops8[j] = 8'(v[j]);
    q[0].push_back('{val: e, due: cyc + 3});
    q[1].push_back('{val: e, due: cyc + 1});
  endtask

  task automatic send5(input int v [5], input int e);
    @(negedge clk);
    v5 = 1;
    for (int j = 0; j < 5; j++) ops5[j] = 8'(v[j]);
    q[2].push_back('{val: e, due: cyc + 3});
  endtask

  task automatic send1(input int v, input int e);
    @(negedge clk);
    v1 = 1;
    ops1[0] = 8'(v);
    q[3].push_back('{val: e, due: cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v8 = 0;
      v5 = 0;
      v1 = 0;
    end
  endtask

  initial begin
    rst_n = 0;
    v8 = 0;
    v5 = 0;
    v1 = 0;
    ops8 = '{default: '0};
    ops5 = '{default: '0};
    ops1 = '{default: '0};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_vo%0d", d), vo[d], 0);
      check($sformatf("rst_out%0d", d), oo[d], 0);
    end
    rst_n = 1;
    for (int i = 0; i < 5; i++) send8(dir[i], dexp[i]);
    send8(all_n, -1024);
    send8(all_p, 1016);
    for (int i = 0; i < 50; i++) begin
      for (int j = 0; j < 8; j++) r[j] = int'($urandom_range(255)) - 128;
      send8(r, sum8(r));
    end
    idle(6);
    hold_val = sum8(bub_a);
    send8(bub_a, hold_val);
    idle(2);
    send8(bub_b, sum8(bub_b));
    repeat (2) begin
      @(negedge clk);
      v8 = 0;
      check("hold_out", oo[0], hold_val);
      check("hold_vo", vo[0], 0);
    end
    idle(5);
    send8(dir[0], dexp[0]);
    send8(dir[1], dexp[1]);
    @(negedge clk);
    v8 = 0;
    rst_n = 0;
    for (int d = 0; d < 4; d++)
      while (q[d].size() != 0 && q[d][$].due > cyc) void'(q[d].pop_back());
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_vo%0d", d), vo[d], 0);
      check($sformatf("midrst_out%0d", d), oo[d], 0);
    end
    v8 = 1;
    for (int j = 0; j < 8; j++) ops8[j] = 8'(dir[3][j]);
    @(negedge clk);
    v8 = 0;
    rst_n = 1;
    idle(6);
    send5(n5a, -10);
    send5(n5b, -640);
    idle(1);
    send1(-7, -7);
    send1(127, 127);
    idle(8);
    for (int d = 0; d < 4; d++) check($sformatf("drain%0d", d), q[d].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
